// File: rtl/reg_pipeline.sv
// reg_pipeline: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Each stage holds one word plus a valid bit. A stall only propagates upstream
// through occupied stages, so empty slots are squeezed out while the output is
// blocked. flush drops every held word. rstn (synchronous, active-low) clears
// all state and wins over everything else.
module reg_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_adv;
  logic [CW-1:0]    w_count;

  // Advance chain, walked from the output side: a stage may load when it is
  // empty or when everything downstream of it is able to move.
  always_comb begin : adv_chain
    logic w_room;
    w_adv  = '0;
    w_room = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_room   = w_room | ~r_valid[i];
      w_adv[i] = w_room;
    end
  end

  // Occupancy is the number of set valid bits, derived straight from registers.
  always_comb begin : occupancy
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CW'(r_valid[i]);
    end
  end

  assign in_ready  = w_adv[0] & ~flush & rstn;
  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign count     = w_count;

  // Stage registers: reset clears everything; flush drops valid bits only;
  // otherwise each stage that can advance takes its upstream neighbour.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      // stage 0 <- input port, stage i <- stage i-1
      if (w_adv[0]) begin
        r_data[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_data[i] <= r_data[i-1];
        end
      end

      if (flush) begin
        r_valid <= '0;
      end else begin
        if (w_adv[0]) begin
          r_valid[0] <= in_valid & in_ready;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (w_adv[i]) begin
            r_valid[i] <= r_valid[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_pipeline.sv
// tb_reg_pipeline: drives a DEPTH=3 and a DEPTH=1 instance with identical
// stimulus and compares both against a list-of-words reference model.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       rstn, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       ir3, ov3, ir1, ov1;
  logic [7:0] od3, od1;
  logic [1:0] cnt3;
  logic [0:0] cnt1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  reg_pipeline #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_ready(ir3), .in_data(in_data), .out_valid(ov3),
    .out_ready(out_ready), .out_data(od3), .count(cnt3)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_ready(ir1), .in_data(in_data), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .count(cnt1)
  );

  // Reference model: per instance, an ordered list of held words (index 0 is
  // the oldest) with the stage number each one currently sits in.
  int         dep [2] = '{3, 1};
  logic [7:0] md  [2][4];
  int         ms  [2][4];
  int         mn  [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check in_ready, take the edge, update the
  // model, then check the registered outputs.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy,
                     input logic fl, input logic rn);
    logic       mv  [2][4];
    logic       exp_rdy [2];
    logic       act_rdy, act_ov;
    logic [7:0] act_od;
    int         act_cnt;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    rstn      = rn;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic adv0;
      for (int j = 0; j < mn[k]; j++) begin
        if (j == 0) mv[k][j] = (ms[k][0] < dep[k] - 1) || ordy;
        else        mv[k][j] = (ms[k][j] + 1 != ms[k][j-1]) || mv[k][j-1];
      end
      adv0 = 1'b1;
      if (mn[k] > 0 && ms[k][mn[k]-1] == 0) adv0 = mv[k][mn[k]-1];
      exp_rdy[k] = rn && !fl && adv0;
      act_rdy = (k == 0) ? ir3 : ir1;
      chk($sformatf("d%0d_in_ready", dep[k]), 32'(act_rdy), 32'(exp_rdy[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rn || fl) begin
        mn[k] = 0;
      end else begin
        int n;
        n = 0;
        for (int j = 0; j < mn[k]; j++) begin
          if (!(j == 0 && ms[k][0] == dep[k] - 1 && ordy)) begin
            md[k][n] = md[k][j];
            ms[k][n] = ms[k][j] + (mv[k][j] ? 1 : 0);
            n++;
          end
        end
        if (iv && exp_rdy[k]) begin
          md[k][n] = id;
          ms[k][n] = 0;
          n++;
        end
        mn[k] = n;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      logic ev;
      act_ov  = (k == 0) ? ov3 : ov1;
      act_od  = (k == 0) ? od3 : od1;
      act_cnt = (k == 0) ? int'(cnt3) : int'(cnt1);
      ev = (mn[k] > 0) && (ms[k][0] == dep[k] - 1);
      chk($sformatf("d%0d_out_valid", dep[k]), 32'(act_ov), 32'(ev));
      chk($sformatf("d%0d_count", dep[k]), 32'(act_cnt), 32'(mn[k]));
      if (ev) chk($sformatf("d%0d_out_data", dep[k]), 32'(act_od), 32'(md[k][0]));
      if (!rn) chk($sformatf("d%0d_out_data_rst", dep[k]), 32'(act_od), 32'h0);
    end
  endtask

  initial begin
    mn[0] = 0;
    mn[1] = 0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // single word latency
    cyc(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // back-to-back streaming of 1..10
    for (int i = 1; i <= 10; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // backpressure, then simultaneous in/out when full
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // bubble collapse under a stalled output
    cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // flush while full with input offered
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // reset mid-stream
    cyc(1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h82, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h83, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h84, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          8'($urandom),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 31) == 0),
          1'($urandom_range(0, 63) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard all held data.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  input word.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  output word, taken from stage DEPTH-1.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-013 SHALL hold DEPTH stages, each a WIDTH-bit data register plus one valid bit; stage 0 is input side, stage DEPTH-1 is output side.
REQ-014 SHALL define input handshake as in_valid && in_ready at a rising edge; output handshake as out_valid && out_ready at a rising edge.
REQ-015 SHALL drive out_valid = valid[DEPTH-1] and out_data = data[DEPTH-1], both purely from registers.
REQ-016 SHALL compute advance[DEPTH-1] = !valid[DEPTH-1] || out_ready.
REQ-017 SHALL compute advance[i] = !valid[i] || advance[i+1] for i < DEPTH-1 (bubble collapsing: a stall propagates upstream only through occupied stages).
REQ-018 SHALL drive in_ready = advance[0] && !flush && rstn.
REQ-019 SHALL, for i >= 1 with advance[i], load data[i] <= data[i-1] and valid[i] <= valid[i-1].
REQ-020 SHALL, with advance[0], load valid[0] <= in_valid && in_ready and data[0] <= in_data.
REQ-021 SHALL leave data[i] and valid[i] unchanged when advance[i] is 0.
REQ-022 SHALL have latency DEPTH: a word accepted at edge t with no downstream stall shows out_valid=1 in the cycle after edge t+DEPTH-1; DEPTH=1 behaves as a D flip-flop with valid/ready.
REQ-023 SHALL sustain one transfer per cycle in both directions when out_ready stays 1.
REQ-024 SHALL preserve word order; no word duplicated or dropped except by flush or reset.
REQ-025 SHALL keep count equal to the popcount of valid[]; count updates on the same edge as valid[].
REQ-026 SHALL, when full (count = DEPTH) and out_ready = 0, drive in_ready = 0 and hold all state.
REQ-027 SHALL, when full and out_ready = 1, allow simultaneous input and output handshakes in the same cycle; count stays DEPTH.
REQ-028 SHALL, when flush = 1 at an edge, clear all valid bits (count -> 0); data registers are not cleared.
REQ-029 SHALL, during a flush cycle, still present out_valid/out_data; an output handshake in that cycle counts as a completed transfer; no input is accepted (in_ready = 0).
REQ-030 SHALL give rstn priority over flush and all handshakes.

Reset
REQ-031 SHALL, on a rising edge with rstn = 0, clear all valid bits and all data registers to 0.
REQ-032 SHALL drive in_ready = 0 while rstn = 0, and out_valid = 0, out_data = 0, count = 0 from the first edge after reset is applied.
REQ-033 SHALL discard any in-flight data on reset asserted mid-operation; first in_ready = 1 is in the first cycle with rstn = 1.

Verification
REQ-034 Latency: DEPTH=3, WIDTH=8, out_ready=1, single word 0xA5 accepted at edge 0 -> out_valid=1, out_data=0xA5 in the cycle after edge 2, exactly one cycle wide.
REQ-035 Streaming: out_ready=1, words 1..10 presented back-to-back -> in_ready constant 1, outputs 1..10 in order on 10 consecutive cycles.
REQ-036 Backpressure: out_ready=0, offer 0x11,0x22,0x33,0x44 -> first three accepted, count=3, in_ready=0 for 0x44; raise out_ready -> 0x11 out and 0x44 accepted in the same cycle, count stays 3.
REQ-037 Bubble collapse: accept 0x01, idle 2 cycles, accept 0x02, out_ready=0 throughout -> count reaches 2, both words adjacent at stages 2 and 1; release -> 0x01 then 0x02 on consecutive cycles.
REQ-038 Flush: count=3, flush=1 with in_valid=1 and out_ready=0 -> in_ready=0, next cycle count=0, out_valid=0, flushed input never appears.
REQ-039 Reset mid-stream: count=2, rstn=0 for one edge -> out_valid=0, out_data=0x00, count=0; DEPTH=1 variant repeats REQ-034 with result one cycle after acceptance.
